// File: rtl/common.sv
// rtl/common.sv - data-bus request/response types shared across the memory system
package common;

   localparam int DATA_W = 64;

   typedef enum logic [1:0] {
      MSIZE1 = 2'd0,
      MSIZE2 = 2'd1,
      MSIZE4 = 2'd2,
      MSIZE8 = 2'd3
   } msize_t;

   typedef struct packed {
      logic              valid;
      logic [DATA_W-1:0] addr;
      msize_t            size;
      logic [7:0]        strobe;
      logic [DATA_W-1:0] data;
   } dbus_req_t;

   typedef struct packed {
      logic              data_ok;
      logic [DATA_W-1:0] data;
   } dbus_resp_t;

endpackage

// File: rtl/mem_access_ctrl_pkg.sv
// rtl/mem_access_ctrl_pkg.sv - size-to-strobe and alignment helpers for the MEM stage
package mem_access_ctrl_pkg;

   import common::*;

   function automatic logic [7:0] base_strobe(input msize_t size);
      case (size)
         MSIZE1:  return 8'h01;
         MSIZE2:  return 8'h03;
         MSIZE4:  return 8'h0F;
         default: return 8'hFF;
      endcase
   endfunction

   function automatic logic addr_misaligned(input logic [2:0] addr_lo, input msize_t size);
      case (size)
         MSIZE1:  return 1'b0;
         MSIZE2:  return addr_lo[0];
         MSIZE4:  return |addr_lo[1:0];
         default: return |addr_lo;
      endcase
   endfunction

endpackage

// File: rtl/temp_storage.sv
// rtl/temp_storage.sv - pipeline register bundles between EX/MEM and MEM/WB
package temp_storage;

   import common::*;

   typedef struct packed {
      logic              mem_read;
      logic              mem_write;
      logic [2:0]        mem_funct3;
      logic [DATA_W-1:0] alu_result;
      logic [DATA_W-1:0] store_data;
      logic [4:0]        reg_dest_addr;
      logic              reg_write_enable;
   } ex_mem;

   typedef struct packed {
      logic [4:0]        reg_dest_addr;
      logic              reg_write_enable;
      logic [DATA_W-1:0] reg_write_data;
   } mem_wb;

endpackage

// File: rtl/mem_align.sv
// rtl/mem_align.sv - byte-lane placement for stores and extraction/extension for loads
// Purely combinational so the cache can share it.
module mem_align #(
   parameter int XLEN = 64
) (
   input  logic [2:0]      addr_lo,
   input  logic [2:0]      funct3,
   input  logic [XLEN-1:0] store_data,
   input  logic [XLEN-1:0] load_data,
   output logic [7:0]      strobe,
   output logic [XLEN-1:0] store_shifted,
   output logic [XLEN-1:0] load_result,
   output logic            misalign
);
   import common::*;
   import mem_access_ctrl_pkg::*;

   msize_t          size;
   logic            sx;
   logic [XLEN-1:0] lane;

   always_comb begin
      size          = msize_t'(funct3[1:0]);
      sx            = ~funct3[2];
      strobe        = base_strobe(size) << addr_lo;
      store_shifted = store_data << {addr_lo, 3'b000};
      lane          = load_data >> {addr_lo, 3'b000};
      misalign      = addr_misaligned(addr_lo, size);
      case (size)
         MSIZE1:  load_result = {{(XLEN-8){sx & lane[7]}}, lane[7:0]};
         MSIZE2:  load_result = {{(XLEN-16){sx & lane[15]}}, lane[15:0]};
         MSIZE4:  load_result = {{(XLEN-32){sx & lane[31]}}, lane[31:0]};
         default: load_result = lane;
      endcase
   end

endmodule

// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - MEM stage sequencer: issues data-bus requests, stalls, formats loads
module mem_access_ctrl
   import common::*;
   import temp_storage::*;
#(
   parameter int XLEN = 64
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       in_valid,
   input  ex_mem      ex_mem_state,
   input  logic       flush,
   output dbus_req_t  dreq,
   input  dbus_resp_t dresp,
   output logic       stall,
   output logic       out_valid,
   output mem_wb      mem_wb_state,
   output logic       misalign
);

   typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RESP} state_t;

   state_t            state_q, state_d;
   logic              req_valid_q, req_valid_d;
   logic [XLEN-1:0]   req_addr_q, req_addr_d;
   msize_t            req_size_q, req_size_d;
   logic [7:0]        req_strobe_q, req_strobe_d;
   logic [XLEN-1:0]   req_data_q, req_data_d;
   logic              is_load_q, is_load_d;
   logic [2:0]        funct3_q, funct3_d;
   logic [4:0]        rd_q, rd_d;
   logic              we_q, we_d;
   logic              flushed_q, flushed_d;
   logic              out_valid_q, out_valid_d;
   logic              misalign_q, misalign_d;
   mem_wb             mem_wb_q, mem_wb_d;

   logic              mem_op;
   logic [2:0]        al_addr;
   logic [2:0]        al_funct3;
   logic [7:0]        al_strobe;
   logic [XLEN-1:0]   al_store;
   logic [XLEN-1:0]   al_load;
   logic              al_misalign;

   // In IDLE the aligner looks at the incoming op; afterwards at the latched request.
   always_comb begin
      mem_op    = ex_mem_state.mem_read | ex_mem_state.mem_write;
      al_addr   = (state_q == S_IDLE) ? ex_mem_state.alu_result[2:0] : req_addr_q[2:0];
      al_funct3 = (state_q == S_IDLE) ? ex_mem_state.mem_funct3 : funct3_q;
   end

   mem_align #(.XLEN(XLEN)) u_align (
      .addr_lo       (al_addr),
      .funct3        (al_funct3),
      .store_data    (ex_mem_state.store_data),
      .load_data     (dresp.data),
      .strobe        (al_strobe),
      .store_shifted (al_store),
      .load_result   (al_load),
      .misalign      (al_misalign)
   );

   always_comb begin
      stall = (state_q == S_BUSY) ||
              ((state_q == S_IDLE) && in_valid && mem_op && !al_misalign);
   end

   always_comb begin
      state_d      = state_q;
      req_valid_d  = req_valid_q;
      req_addr_d   = req_addr_q;
      req_size_d   = req_size_q;
      req_strobe_d = req_strobe_q;
      req_data_d   = req_data_q;
      is_load_d    = is_load_q;
      funct3_d     = funct3_q;
      rd_d         = rd_q;
      we_d         = we_q;
      flushed_d    = flushed_q;
      out_valid_d  = 1'b0;
      misalign_d   = 1'b0;
      mem_wb_d     = mem_wb_q;

      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               if (!mem_op) begin
                  out_valid_d              = ~flush;
                  mem_wb_d.reg_dest_addr    = ex_mem_state.reg_dest_addr;
                  mem_wb_d.reg_write_enable = ex_mem_state.reg_write_enable;
                  mem_wb_d.reg_write_data   = ex_mem_state.alu_result;
               end else if (al_misalign) begin
                  out_valid_d              = ~flush;
                  misalign_d               = ~flush;
                  mem_wb_d.reg_dest_addr    = ex_mem_state.reg_dest_addr;
                  mem_wb_d.reg_write_enable = 1'b0;
                  mem_wb_d.reg_write_data   = ex_mem_state.alu_result;
               end else begin
                  state_d      = S_BUSY;
                  req_valid_d  = 1'b1;
                  req_addr_d   = ex_mem_state.alu_result;
                  req_size_d   = msize_t'(ex_mem_state.mem_funct3[1:0]);
                  req_strobe_d = ex_mem_state.mem_write ? al_strobe : 8'h00;
                  req_data_d   = ex_mem_state.mem_write ? al_store : '0;
                  is_load_d    = ex_mem_state.mem_read & ~ex_mem_state.mem_write;
                  funct3_d     = ex_mem_state.mem_funct3;
                  rd_d         = ex_mem_state.reg_dest_addr;
                  we_d         = ex_mem_state.reg_write_enable;
                  flushed_d    = flush;
               end
            end
         end
         S_BUSY: begin
            // A flushed transaction still completes on the bus; only its writeback is dropped.
            flushed_d = flushed_q | flush;
            if (dresp.data_ok) begin
               state_d                   = S_RESP;
               req_valid_d               = 1'b0;
               out_valid_d               = ~(flushed_q | flush);
               mem_wb_d.reg_dest_addr    = rd_q;
               mem_wb_d.reg_write_enable = we_q & is_load_q;
               mem_wb_d.reg_write_data   = is_load_q ? al_load : '0;
            end
         end
         default: begin
            state_d   = S_IDLE;
            flushed_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= S_IDLE;
         req_valid_q  <= 1'b0;
         req_addr_q   <= '0;
         req_size_q   <= MSIZE1;
         req_strobe_q <= '0;
         req_data_q   <= '0;
         is_load_q    <= 1'b0;
         funct3_q     <= '0;
         rd_q         <= '0;
         we_q         <= 1'b0;
         flushed_q    <= 1'b0;
         out_valid_q  <= 1'b0;
         misalign_q   <= 1'b0;
         mem_wb_q     <= '0;
      end else begin
         state_q      <= state_d;
         req_valid_q  <= req_valid_d;
         req_addr_q   <= req_addr_d;
         req_size_q   <= req_size_d;
         req_strobe_q <= req_strobe_d;
         req_data_q   <= req_data_d;
         is_load_q    <= is_load_d;
         funct3_q     <= funct3_d;
         rd_q         <= rd_d;
         we_q         <= we_d;
         flushed_q    <= flushed_d;
         out_valid_q  <= out_valid_d;
         misalign_q   <= misalign_d;
         mem_wb_q     <= mem_wb_d;
      end
   end

   always_comb begin
      dreq.valid   = req_valid_q;
      dreq.addr    = req_addr_q;
      dreq.size    = req_size_q;
      dreq.strobe  = req_strobe_q;
      dreq.data    = req_data_q;
      out_valid    = out_valid_q;
      misalign     = misalign_q;
      mem_wb_state = mem_wb_q;
   end

endmodule
